// File: rtl/spi_read_sched_pkg.sv
// Shared definitions for the SPI read scheduler: FSM state encoding,
// bit-phase constants and default parameter values.
package spi_read_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Each SPI bit spans two system clocks: SCK low, then SCK high.
  localparam logic       PH_LOW   = 1'b0;
  localparam logic       PH_HIGH  = 1'b1;
  localparam logic [2:0] LAST_BIT = 3'd7;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_LEN_W      = 4;
  localparam int DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/spi_read_sched_if.sv
// Requester-side handshake plus SPI pins of the read scheduler.
// master: the scheduler; slave: the requesters together with the SPI device.
interface spi_read_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [8*NUM_REQ-1:0]     req_addr;
  logic [LEN_W*NUM_REQ-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic [7:0]               rd_data;
  logic [NUM_REQ-1:0]       rd_valid;
  logic [NUM_REQ-1:0]       done;
  logic                     spi_cs;
  logic                     spi_sck;
  logic                     spi_mosi_out;
  logic                     spi_miso_in;

  modport master (
    input  req, req_addr, req_len, spi_miso_in,
    output grant, rd_data, rd_valid, done, spi_cs, spi_sck, spi_mosi_out
  );

  modport slave (
    output req, req_addr, req_len, spi_miso_in,
    input  grant, rd_data, rd_valid, done, spi_cs, spi_sck, spi_mosi_out
  );
endinterface

// File: rtl/spi_read_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] oh;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot = (req >> ptr) | (req << (NUM_REQ - ptr));
    oh  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    grant   = (oh << ptr) | (oh >> (NUM_REQ - ptr));
    any_req = |req;
  end

endmodule

// File: rtl/spi_read_sched.sv
// Round-robin scheduler sharing one mode-0 SPI bus among NUM_REQ requesters.
// Each transaction shifts one address byte out on MOSI, then reads len bytes
// MSB first from MISO and returns them to the owner with a one-hot valid.
module spi_read_sched
  import spi_read_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic              spi_clk,
  input logic              n_reset,
  spi_read_sched_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               any_req;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [7:0]         addr_sel;
  logic [LEN_W-1:0]   len_sel;
  logic [NUM_REQ-1:0] grant_r, rd_valid_r, done_r;
  logic [7:0]         rd_data_r;
  logic               phase;
  logic [2:0]         bit_cnt;
  logic [LEN_W-1:0]   byte_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [7:0]         addr_sh;
  logic [6:0]         rx_sh;
  logic               byte_done, last_byte, gap_end;
  logic               cs_c, sck_c, mosi_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req     (bus.req),
    .ptr     (ptr),
    .grant   (arb_gnt),
    .any_req (any_req)
  );

  // Select the winner's address/length and the pointer just past it.
  always_comb begin
    addr_sel = '0;
    len_sel  = '0;
    ptr_nxt  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        addr_sel = bus.req_addr[8*i +: 8];
        len_sel  = bus.req_len[LEN_W*i +: LEN_W];
        ptr_nxt  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign byte_done = (state == ST_DATA) && (phase == PH_HIGH) && (bit_cnt == LAST_BIT);
  assign last_byte = byte_done && (byte_cnt == LEN_W'(1));
  assign gap_end   = (state == ST_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and SPI pin levels, decoded from the current state and phase.
  always_comb begin
    state_nxt = state;
    cs_c      = 1'b1;
    sck_c     = 1'b0;
    mosi_c    = 1'b0;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_SETUP;
      ST_SETUP: begin
        cs_c      = 1'b0;
        mosi_c    = addr_sh[7];
        state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        cs_c   = 1'b0;
        sck_c  = (phase == PH_HIGH);
        mosi_c = addr_sh[7];
        if ((phase == PH_HIGH) && (bit_cnt == LAST_BIT)) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        cs_c  = 1'b0;
        sck_c = (phase == PH_HIGH);
        if (last_byte) state_nxt = ST_GAP;
      end
      ST_GAP:   if (gap_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Grant, pointer, bit/byte/gap counters and the returned-byte pulses.
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      ptr        <= '0;
      grant_r    <= '0;
      phase      <= PH_LOW;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= '0;
      done_r     <= '0;
    end else begin
      rd_valid_r <= '0;
      done_r     <= '0;
      case (state)
        ST_IDLE: begin
          phase   <= PH_LOW;
          bit_cnt <= '0;
          gap_cnt <= '0;
          if (any_req) begin
            grant_r  <= arb_gnt;
            ptr      <= ptr_nxt;
            byte_cnt <= (len_sel == '0) ? LEN_W'(1) : len_sel;
          end
        end
        ST_ADDR, ST_DATA: begin
          phase <= ~phase;
          if (phase == PH_HIGH) bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            rd_data_r  <= {rx_sh, bus.spi_miso_in};
            rd_valid_r <= grant_r;
            byte_cnt   <= byte_cnt - LEN_W'(1);
            if (last_byte) done_r <= grant_r;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_end) grant_r <= '0;
        end
        default: ;
      endcase
    end
  end

  // Address shift-out and MISO shift-in; always reloaded before use.
  always_ff @(posedge spi_clk) begin
    if ((state == ST_IDLE) && any_req)
      addr_sh <= addr_sel;
    else if ((state == ST_ADDR) && (phase == PH_HIGH))
      addr_sh <= {addr_sh[6:0], 1'b0};
    if ((state == ST_DATA) && (phase == PH_HIGH))
      rx_sh <= {rx_sh[5:0], bus.spi_miso_in};
  end

  assign bus.grant        = grant_r;
  assign bus.rd_data      = rd_data_r;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.done         = done_r;
  assign bus.spi_cs       = cs_c;
  assign bus.spi_sck      = sck_c;
  assign bus.spi_mosi_out = mosi_c;

endmodule
